adder_accum: RTL
================

# adder_accum

Parametrised successor to the team's 4-bit combinational adder. It is a WIDTH-bit registered add/subtract/accumulate unit with a valid/ready handshake on both sides, a one-deep output register, a running accumulator and optional saturation. It sits between a request source, such as the pin-level input decoder, and a consumer that may stall, and it provides one result per accepted operation.

## Interface
- WIDTH, default 4: operand width in bits; results are WIDTH+1 bits.
- SAT, default 0: 0 = accumulator wraps on overflow; 1 = accumulator clamps to all-ones.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  reset, asynchronous assert, active-low (0 = in reset).
- ena  in  1  global enable; 0 blocks acceptance of new operations.
- mode  in  2  operation, sampled with a/b: 00 ADD, 01 SUB, 10 ACC, 11 CLR.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B; ignored in ACC and CLR.
- in_valid  in  1  operation present on mode/a/b.
- in_ready  out  1  block can accept this cycle.
- z  out  WIDTH+1  registered result.
- z_valid  out  1  z holds an unconsumed result.
- z_ready  in  1  consumer takes z this cycle.
- acc  out  WIDTH+1  current accumulator value.
- ovf  out  1  sticky accumulator overflow flag.

## Operation
- Accept condition: in_valid & in_ready.
- in_ready = reset & ena & (~z_valid | z_ready). This is combinational, with no dependency on in_valid.
- ADD: z = a + b, zero-extended, exact. The carry lands in z[WIDTH].
- SUB: z = (a − b) mod 2^(WIDTH+1). z[WIDTH] = 1 exactly when a < b (borrow).
- ACC:
  - sum = acc + a, computed WIDTH+2 wide.
  - If sum ≥ 2^(WIDTH+1), ovf is set.
  - SAT=0: acc becomes sum mod 2^(WIDTH+1).
  - SAT=1: acc becomes all-ones.
  - z = new acc value.
- CLR: acc = 0, ovf = 0, z = 0. It is a normal transaction and produces a result beat.
- acc and ovf change only on an accepted ACC or CLR operation. ADD and SUB leave them untouched.
- ovf stays set until CLR or reset.
- Output register behaviour:
  - On accept, z is loaded and z_valid is set.
  - On z_ready & z_valid without an accept, z_valid clears and z holds its last value.
  - Pop and accept in the same cycle: the new result replaces the old one and z_valid stays 1.
- ena=0:
  - No new accepts.
  - A pending z can still be drained by z_ready.
  - acc, ovf and z hold.
- Reset, asynchronous at any time including mid-stall:
  - z=0, z_valid=0, acc=0, ovf=0; in_ready=0 while reset=0.
  - Any in-flight result is discarded.

## Timing
- Latency: operation accepted at edge N; z/z_valid visible after edge N, i.e. in cycle N+1.
- Throughput: one operation per cycle while z_ready=1 and ena=1.
- Back-to-back ACC operations chain correctly: each one uses the acc value updated by the previous accept.
- acc and ovf are registered outputs, updated on the same edge as z.
- No combinational path from in_valid, a, b or mode to any output. in_ready depends only on z_valid, z_ready, ena and reset.

## Structure
- Shared package adder_pkg: mode encoding constants MODE_ADD, MODE_SUB, MODE_ACC, MODE_CLR, and a 2-bit mode typedef. Reused by the input decoder.
- Sub-module adder_core: combinational (WIDTH+1)-bit add/subtract with carry-out. Instantiated once, with operand muxing (b vs acc, invert for SUB) in the parent.
- Parent contains: handshake logic, output register, accumulator, saturation mux, sticky flag.

## Test plan
All scenarios use WIDTH=4.
- Reset: assert reset=0 mid-stream with z_valid=1 -> z=0, z_valid=0, acc=0, ovf=0, in_ready=0. Release -> in_ready=1 with ena=1.
- ADD: a=9, b=8, z_ready=1 -> next cycle z=17 (10001), z_valid=1. a=15, b=15 -> z=30.
- SUB: a=3, b=5 -> z=30 (11110), z[4]=1. a=5, b=3 -> z=2.
- ACC with SAT=0: CLR, then a=15 three times -> z=15, 30, 13; ovf=1 after the third. Repeat with SAT=1 -> z=15, 30, 31; ovf=1.
- Backpressure: z_valid=1, z_ready=0 -> in_ready=0, z holds its value for 5 cycles. Raise z_ready with in_valid=1 -> accept the same cycle, new z next cycle, no lost or duplicated beat over 8 back-to-back operations.
- ena and CLR: ena=0 with in_valid=1 -> no accept, acc unchanged. CLR after overflow -> acc=0, ovf=0, z=0. Then ACC a=2 -> z=2.

Source files
------------

// File: rtl/adder_pkg.sv
// adder_pkg: shared definitions for the adder/accumulator datapath and the
// input decoder that feeds it.
//   mode_t   : 2-bit operation code carried alongside the operands
//   MODE_*   : operation encodings (ADD, SUB, ACC, CLR)
package adder_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_ADD = 2'b00;
    localparam mode_t MODE_SUB = 2'b01;
    localparam mode_t MODE_ACC = 2'b10;
    localparam mode_t MODE_CLR = 2'b11;

endpackage

// File: rtl/adder_accum_if.sv
// adder_accum_if: request/response bundle for adder_accum.
//   mode, a, b, in_valid -> operation request (source to block)
//   in_ready             <- block can accept this cycle
//   z, z_valid           <- registered result and its valid flag
//   z_ready              -> consumer takes z this cycle
//   acc, ovf             <- running accumulator and sticky overflow flag
// master: request source / result consumer side. slave: the block itself.
interface adder_accum_if #(
    parameter int WIDTH = 4
);
    import adder_pkg::*;

    mode_t            mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH:0]   z;
    logic             z_valid;
    logic             z_ready;
    logic [WIDTH:0]   acc;
    logic             ovf;

    modport master (
        output mode, a, b, in_valid, z_ready,
        input  in_ready, z, z_valid, acc, ovf
    );

    modport slave (
        input  mode, a, b, in_valid, z_ready,
        output in_ready, z, z_valid, acc, ovf
    );

endinterface

// File: rtl/adder_core.sv
// adder_core: combinational (WIDTH+1)-bit adder with carry-in and carry-out.
//   x_i, y_i : operands (WIDTH+1 bits)
//   cin_i    : carry-in (1 turns an inverted y_i into a two's-complement subtract)
//   sum_o    : x_i + y_i + cin_i, modulo 2^(WIDTH+1)
//   cout_o   : carry out of the top bit
module adder_core #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH:0] x_i,
    input  logic [WIDTH:0] y_i,
    input  logic           cin_i,
    output logic [WIDTH:0] sum_o,
    output logic           cout_o
);

    assign {cout_o, sum_o} = {1'b0, x_i} + {1'b0, y_i} + {{(WIDTH+1){1'b0}}, cin_i};

endmodule

// File: rtl/adder_accum.sv
// adder_accum: registered add / subtract / accumulate unit with valid/ready
// handshake on both sides and a one-deep output register.
//   clk   : rising-edge clock
//   reset : asynchronous, active-low reset (0 = in reset)
//   ena   : global enable; 0 blocks new operations (pending z can still drain)
//   bus   : adder_accum_if.slave (mode/a/b/in_valid/in_ready,
//           z/z_valid/z_ready, acc, ovf)
//   WIDTH : operand width; results are WIDTH+1 bits
//   SAT   : 0 = accumulator wraps on overflow, 1 = clamps to all-ones
module adder_accum
    import adder_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter bit SAT   = 1'b0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ena,
    adder_accum_if.slave  bus
);

    logic [WIDTH:0] z_q,   z_d;
    logic           z_valid_q, z_valid_d;
    logic [WIDTH:0] acc_q, acc_d;
    logic           ovf_q, ovf_d;

    logic           in_ready;
    logic           accept;
    logic [WIDTH:0] x, y, sum;
    logic           cin, cout;

    // Clamp only when the accumulate carried out of the result width.
    function automatic logic [WIDTH:0] sat_acc(input logic [WIDTH:0] s, input logic carry);
        if (SAT && carry) return '1;
        return s;
    endfunction

    // Ready never looks at in_valid, so no request-side signal reaches an output.
    assign in_ready = reset & ena & (~z_valid_q | bus.z_ready);
    assign accept   = bus.in_valid & in_ready;

    // Operand steering: SUB feeds ~b with carry-in 1; ACC adds a onto acc.
    always_comb begin
        x   = {1'b0, bus.a};
        y   = {1'b0, bus.b};
        cin = 1'b0;
        case (bus.mode)
            MODE_SUB: begin
                y   = ~{1'b0, bus.b};
                cin = 1'b1;
            end
            MODE_ACC: begin
                x = acc_q;
                y = {1'b0, bus.a};
            end
            default: ;
        endcase
    end

    adder_core #(.WIDTH(WIDTH)) u_core (
        .x_i    (x),
        .y_i    (y),
        .cin_i  (cin),
        .sum_o  (sum),
        .cout_o (cout)
    );

    always_comb begin
        z_d       = z_q;
        z_valid_d = z_valid_q;
        acc_d     = acc_q;
        ovf_d     = ovf_q;
        if (accept) begin
            // An accept in the same cycle as a pop replaces the old result.
            z_valid_d = 1'b1;
            case (bus.mode)
                MODE_ADD, MODE_SUB: z_d = sum;
                MODE_ACC: begin
                    acc_d = sat_acc(sum, cout);
                    ovf_d = ovf_q | cout;
                    z_d   = acc_d;
                end
                default: begin
                    acc_d = '0;
                    ovf_d = 1'b0;
                    z_d   = '0;
                end
            endcase
        end else if (bus.z_ready && z_valid_q) begin
            z_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            z_q       <= '0;
            z_valid_q <= 1'b0;
            acc_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            z_q       <= z_d;
            z_valid_q <= z_valid_d;
            acc_q     <= acc_d;
            ovf_q     <= ovf_d;
        end
    end

    assign bus.in_ready = in_ready;
    assign bus.z        = z_q;
    assign bus.z_valid  = z_valid_q;
    assign bus.acc      = acc_q;
    assign bus.ovf      = ovf_q;

endmodule
